// File: rtl/bcd_down_timer.sv
// bcd_down_timer
// Multi-digit BCD countdown timer. A clamped BCD preset is loaded, then
// decremented once every TICK_DIV clock cycles while running, with BCD
// borrow across digits. The timer stops at zero and flags completion with a
// level (done) and a one-cycle pulse (done_pulse).
//
// Optional build macro: BCD_TIMER_AUTO_RELOAD_EN
//   When defined, a decrement that reaches zero reloads the last loaded
//   preset and keeps running (done_pulse fires each time, done stays low).
//   A zero preset still ends in DONE.
module bcd_down_timer #(
  parameter int DIGITS   = 2,
  parameter int TICK_DIV = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  input  logic                  start,
  input  logic                  pause,
  output logic [4*DIGITS-1:0]   q,
  output logic                  running,
  output logic                  done,
  output logic                  done_pulse
);

  localparam int W  = 4 * DIGITS;
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [PW-1:0] PRESC_ZERO = {PW{1'b0}};
  localparam logic [PW-1:0] PRESC_ONE  = PW'(1);
  localparam logic [PW-1:0] PRESC_MAX  = PW'(TICK_DIV - 1);
  localparam logic [W-1:0]  Q_ZERO     = {W{1'b0}};

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_PAUSED = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  // Clamp every BCD digit above 9 down to 9.
  function automatic logic [W-1:0] bcd_clamp(input logic [W-1:0] v);
    logic [W-1:0] r;
    r = v;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) begin
        r[4*i +: 4] = 4'd9;
      end else begin
        r[4*i +: 4] = v[4*i +: 4];
      end
    end
    return r;
  endfunction

  // Subtract one in BCD: zero digits become 9 and pass the borrow upward,
  // the first non-zero digit absorbs it.
  function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         borrow;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (borrow) begin
        if (v[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end else begin
        r[4*i +: 4] = v[4*i +: 4];
      end
    end
    return r;
  endfunction

  state_t          state_r, state_s;
  logic [W-1:0]    q_r, q_s;
  logic [PW-1:0]   presc_r, presc_s;
  logic            running_r, running_s;
  logic            done_r, done_s;
  logic            done_pulse_r, done_pulse_s;

  logic [W-1:0]    load_clamped_s;
  logic [W-1:0]    dec_val_s;
  logic            q_zero_s;
  logic            dec_zero_s;
  logic            tick_s;
  logic            start_ok_s;
  logic            reload_hit_s;
  logic [W-1:0]    reload_val_s;

  assign load_clamped_s = bcd_clamp(load_val);
  assign dec_val_s      = bcd_dec(q_r);
  assign q_zero_s       = (q_r == Q_ZERO);
  assign dec_zero_s     = (dec_val_s == Q_ZERO);
  // A decrement step happens only in RUN, at terminal count, when neither
  // load nor pause claims the cycle.
  assign tick_s         = (state_r == S_RUN) && (presc_r == PRESC_MAX) && !load && !pause;
  assign start_ok_s     = start && !load && ((state_r == S_IDLE) || (state_r == S_PAUSED));

`ifdef BCD_TIMER_AUTO_RELOAD_EN
  logic [W-1:0] reload_r;

  // Reload register: remembers the last clamped preset for auto reload.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reload_r <= Q_ZERO;
    end else if (load) begin
      reload_r <= load_clamped_s;
    end else begin
      reload_r <= reload_r;
    end
  end

  assign reload_hit_s = (reload_r != Q_ZERO);
  assign reload_val_s = reload_r;
`else
  assign reload_hit_s = 1'b0;
  assign reload_val_s = Q_ZERO;
`endif

  // State and registered-output update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= S_IDLE;
      q_r          <= Q_ZERO;
      presc_r      <= PRESC_ZERO;
      running_r    <= 1'b0;
      done_r       <= 1'b0;
      done_pulse_r <= 1'b0;
    end else begin
      state_r      <= state_s;
      q_r          <= q_s;
      presc_r      <= presc_s;
      running_r    <= running_s;
      done_r       <= done_s;
      done_pulse_r <= done_pulse_s;
    end
  end

  // Next-state decode with load > pause > start priority.
  always_comb begin
    state_s = state_r;
    if (load) begin
      state_s = S_IDLE;
    end else begin
      case (state_r)
        S_IDLE, S_PAUSED: begin
          if (start) begin
            state_s = q_zero_s ? S_DONE : S_RUN;
          end else begin
            state_s = state_r;
          end
        end
        S_RUN: begin
          if (pause) begin
            state_s = S_PAUSED;
          end else if (tick_s && dec_zero_s && !reload_hit_s) begin
            state_s = S_DONE;
          end else begin
            state_s = S_RUN;
          end
        end
        S_DONE: begin
          state_s = S_DONE;
        end
        default: begin
          state_s = S_IDLE;
        end
      endcase
    end
  end

  // Datapath and output decode: count value, prescaler and status flags.
  always_comb begin
    q_s          = q_r;
    presc_s      = presc_r;
    running_s    = (state_s == S_RUN);
    done_s       = (state_s == S_DONE);
    done_pulse_s = (start_ok_s && q_zero_s) || (tick_s && dec_zero_s);

    if (load) begin
      q_s = load_clamped_s;
    end else if (tick_s) begin
      if (dec_zero_s && reload_hit_s) begin
        q_s = reload_val_s;
      end else begin
        q_s = dec_val_s;
      end
    end else begin
      q_s = q_r;
    end

    if (load) begin
      presc_s = PRESC_ZERO;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (start) begin
            presc_s = PRESC_ZERO;
          end else begin
            presc_s = presc_r;
          end
        end
        S_RUN: begin
          if (pause) begin
            presc_s = presc_r;
          end else if (presc_r == PRESC_MAX) begin
            presc_s = PRESC_ZERO;
          end else begin
            presc_s = presc_r + PRESC_ONE;
          end
        end
        S_PAUSED: begin
          presc_s = presc_r;
        end
        S_DONE: begin
          presc_s = presc_r;
        end
        default: begin
          presc_s = PRESC_ZERO;
        end
      endcase
    end
  end

  assign q          = q_r;
  assign running    = running_r;
  assign done       = done_r;
  assign done_pulse = done_pulse_r;

endmodule

// File: tb/tb_bcd_down_timer.sv
// tb_bcd_down_timer
// Three timers (TICK_DIV 1, 2, 4) share one stimulus stream. A behavioural
// model keeps the count as a plain integer and the phase as a cycle count,
// and every output of every instance is compared after each clock edge.
module tb_bcd_down_timer;

  localparam int DIG = 2;
  localparam int N   = 3;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_DONE = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       load = 1'b0;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic [7:0] load_val = 8'h00;

  logic [7:0] dq [N];
  logic       drun [N];
  logic       ddone [N];
  logic       ddp [N];

  int td [N] = '{1, 2, 4};

  int m_state [N];
  int m_q [N];
  int m_presc [N];
  int m_reload [N];
  bit m_dp [N];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bcd_down_timer #(.DIGITS(DIG), .TICK_DIV(1)) dut1 (
    .clk(clk), .rst(rst), .load(load), .load_val(load_val), .start(start), .pause(pause),
    .q(dq[0]), .running(drun[0]), .done(ddone[0]), .done_pulse(ddp[0]));
  bcd_down_timer #(.DIGITS(DIG), .TICK_DIV(2)) dut2 (
    .clk(clk), .rst(rst), .load(load), .load_val(load_val), .start(start), .pause(pause),
    .q(dq[1]), .running(drun[1]), .done(ddone[1]), .done_pulse(ddp[1]));
  bcd_down_timer #(.DIGITS(DIG), .TICK_DIV(4)) dut4 (
    .clk(clk), .rst(rst), .load(load), .load_val(load_val), .start(start), .pause(pause),
    .q(dq[2]), .running(drun[2]), .done(ddone[2]), .done_pulse(ddp[2]));

  // BCD preset to integer, digits above 9 read as 9.
  function automatic int clamp_to_int(input logic [7:0] v);
    int r, d, w;
    r = 0;
    w = 1;
    for (int i = 0; i < DIG; i++) begin
      d = int'(v[4*i +: 4]);
      if (d > 9) d = 9;
      r = r + d * w;
      w = w * 10;
    end
    return r;
  endfunction

  function automatic logic [7:0] int_to_bcd(input int v);
    logic [7:0] r;
    int x;
    x = v;
    r = 8'h00;
    for (int i = 0; i < DIG; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      m_state[k] = M_IDLE; m_q[k] = 0; m_presc[k] = 0; m_reload[k] = 0; m_dp[k] = 1'b0;
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < N; k++) begin
      m_dp[k] = 1'b0;
      if (load) begin
        m_q[k] = clamp_to_int(load_val);
        m_reload[k] = m_q[k];
        m_state[k] = M_IDLE;
        m_presc[k] = 0;
      end else if (pause && m_state[k] == M_RUN) begin
        m_state[k] = M_PAUSED;
      end else if (start && (m_state[k] == M_IDLE || m_state[k] == M_PAUSED)) begin
        if (m_q[k] == 0) begin
          m_state[k] = M_DONE;
          m_dp[k] = 1'b1;
        end else begin
          if (m_state[k] == M_IDLE) m_presc[k] = 0;
          m_state[k] = M_RUN;
        end
      end else if (m_state[k] == M_RUN) begin
        if (m_presc[k] == td[k] - 1) begin
          m_presc[k] = 0;
          m_q[k] = m_q[k] - 1;
          if (m_q[k] == 0) begin
            m_dp[k] = 1'b1;
`ifdef BCD_TIMER_AUTO_RELOAD_EN
            if (m_reload[k] != 0) m_q[k] = m_reload[k];
            else m_state[k] = M_DONE;
`else
            m_state[k] = M_DONE;
`endif
          end
        end else begin
          m_presc[k] = m_presc[k] + 1;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < N; k++) begin
      chk($sformatf("q_td%0d", td[k]), {24'h0, dq[k]}, {24'h0, int_to_bcd(m_q[k])});
      chk($sformatf("running_td%0d", td[k]), {31'h0, drun[k]}, {31'h0, (m_state[k] == M_RUN)});
      chk($sformatf("done_td%0d", td[k]), {31'h0, ddone[k]}, {31'h0, (m_state[k] == M_DONE)});
      chk($sformatf("done_pulse_td%0d", td[k]), {31'h0, ddp[k]}, {31'h0, m_dp[k]});
    end
  endtask

  // One clock: drive inputs at the falling edge, step the model with them at
  // the rising edge, compare just after, then clear the strobes.
  task automatic cycle(input logic l, input logic [7:0] lv, input logic s, input logic p);
    load = l; load_val = lv; start = s; pause = p;
    @(posedge clk);
    model_step();
    #1;
    check_all();
    @(negedge clk);
    load = 1'b0; start = 1'b0; pause = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, load_val, 1'b0, 1'b0);
  endtask

`ifdef BCD_TIMER_AUTO_RELOAD_EN
  logic [7:0] ar_seq [9] = '{8'h02, 8'h01, 8'h03, 8'h02, 8'h01, 8'h03, 8'h02, 8'h01, 8'h03};
`endif

  initial begin
    model_reset();
    #1 rst = 1'b1;
    #1;
    check_all();
    chk("reset_q", {24'h0, dq[1]}, 32'h00);
    @(negedge clk);
    rst = 1'b0;

    // Full countdown from 12 on the TICK_DIV=2 instance.
    cycle(1'b1, 8'h12, 1'b0, 1'b0);
    cycle(1'b0, 8'h12, 1'b1, 1'b0);
    idle(23);
    chk("cnt_q_23", {24'h0, dq[1]}, 32'h01);
    chk("cnt_done_23", {31'h0, ddone[1]}, 32'h0);
    idle(1);
    chk("cnt_q_24", {24'h0, dq[1]}, 32'h00);
    chk("cnt_done_24", {31'h0, ddone[1]}, 32'h1);
    chk("cnt_run_24", {31'h0, drun[1]}, 32'h0);
    chk("cnt_dp_24", {31'h0, ddp[1]}, 32'h1);
    idle(1);
    chk("cnt_dp_25", {31'h0, ddp[1]}, 32'h0);
    idle(3);

    // Borrow across digits and clamping.
    cycle(1'b1, 8'h10, 1'b0, 1'b0);
    cycle(1'b0, 8'h10, 1'b1, 1'b0);
    idle(2);
    chk("borrow_q", {24'h0, dq[1]}, 32'h09);
    cycle(1'b1, 8'hAF, 1'b0, 1'b0);
    chk("clamp_AF", {24'h0, dq[1]}, 32'h99);
    cycle(1'b1, 8'h9A, 1'b0, 1'b0);
    chk("clamp_9A", {24'h0, dq[2]}, 32'h99);

    // Pause two cycles into a tick, hold, then resume.
    cycle(1'b1, 8'h05, 1'b0, 1'b0);
    cycle(1'b0, 8'h05, 1'b1, 1'b0);
    idle(2);
    cycle(1'b0, 8'h05, 1'b0, 1'b1);
    idle(10);
    chk("pause_hold_q", {24'h0, dq[2]}, 32'h05);
    cycle(1'b0, 8'h05, 1'b1, 1'b0);
    idle(1);
    chk("resume_q_1", {24'h0, dq[2]}, 32'h05);
    idle(1);
    chk("resume_q_2", {24'h0, dq[2]}, 32'h04);

    // Command priority.
    cycle(1'b1, 8'h37, 1'b1, 1'b0);
    chk("prio_load_q", {24'h0, dq[2]}, 32'h37);
    chk("prio_load_run", {31'h0, drun[2]}, 32'h0);
    cycle(1'b0, 8'h37, 1'b1, 1'b0);
    idle(1);
    cycle(1'b0, 8'h37, 1'b1, 1'b1);
    chk("prio_pause_run", {31'h0, drun[2]}, 32'h0);

    // Asynchronous reset between edges while running.
    cycle(1'b1, 8'h50, 1'b0, 1'b0);
    cycle(1'b0, 8'h50, 1'b1, 1'b0);
    idle(3);
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    chk("arst_q", {24'h0, dq[2]}, 32'h00);
    @(negedge clk);
    rst = 1'b0;
    cycle(1'b0, 8'h50, 1'b1, 1'b0);
    chk("arst_start_done", {31'h0, ddone[1]}, 32'h1);
    chk("arst_start_dp", {31'h0, ddp[1]}, 32'h1);

`ifdef BCD_TIMER_AUTO_RELOAD_EN
    // Auto reload on the TICK_DIV=1 instance.
    cycle(1'b1, 8'h03, 1'b0, 1'b0);
    cycle(1'b0, 8'h03, 1'b1, 1'b0);
    for (int i = 0; i < 9; i++) begin
      idle(1);
      chk($sformatf("ar_q_%0d", i), {24'h0, dq[0]}, {24'h0, ar_seq[i]});
      chk($sformatf("ar_dp_%0d", i), {31'h0, ddp[0]}, {31'h0, (ar_seq[i] == 8'h03)});
      chk($sformatf("ar_done_%0d", i), {31'h0, ddone[0]}, 32'h0);
      chk($sformatf("ar_run_%0d", i), {31'h0, drun[0]}, 32'h1);
    end
`endif

    // Randomized command stream against the model.
    for (int i = 0; i < 1500; i++) begin
      cycle(($urandom % 20) == 0, 8'($urandom), ($urandom % 6) == 0, ($urandom % 10) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
